uart_rx_param: RTL and testbench

Parametrised oversampling UART receiver, the next generation of the fixed 18-bit receiver.
- Adds configurable word width, oversample ratio, optional parity, stop-bit (framing) checking, a receive FIFO and overrun detection.
- Sits between the chip-level serial input pin and the configuration/readout logic.
- Runs on the oversampled receive clock.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_param.sv | 156 +++++++++++++++
 tb/tb_uart_rx_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int MAX_WIDTH = 64;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Parity error term before folding in the received parity bit.
  function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive buffer; head word reads as zero while empty.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          rd_en,
  output logic [DW-1:0]                 rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_w(DEPTH+1)-1:0]     count
);

  localparam int PW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          empty_r, full_r;
  logic          do_push_s, do_pop_s;

  // A pop on an empty buffer is ignored; a push on a full one only lands alongside a pop.
  always_comb begin
    do_pop_s  = rd_en && !empty_r;
    do_push_s = wr_en && (!full_r || do_pop_s);
    count_s   = count_r;
    if (do_push_s && !do_pop_s) begin
      count_s = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Pointer, occupancy and status flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_s;
      empty_r <= (count_s == {CW{1'b0}});
      full_r  <= (count_s == CW'(DEPTH));
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = empty_r ? {DW{1'b0}} : mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: input synchroniser, framing FSM, shifter and receive FIFO.
import uart_pkg::*;

module uart_rx_param #(
  parameter int WIDTH      = 18,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             rxclk,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             uld_rx_data,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_empty,
  output logic             rx_full,
  output logic             overrun
);

  localparam int SW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(WIDTH + 1);
  localparam int CW = cnt_w(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] MID_C  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] CTR_C  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_C = BW'(WIDTH - 1);
  localparam logic          ODD_C  = (PARITY_ODD != 0);

  logic             rx_d1, rx_d2;
  rx_state_t        state_r, state_s;
  logic [SW-1:0]    samp_cnt_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic             perr_r, overrun_r;
  logic             mid_s, centre_s, push_s, drop_s;
  logic [WIDTH+1:0] push_word_s, head_s;
  logic [CW-1:0]    fifo_count_s;

  assign mid_s    = (samp_cnt_r == MID_C);
  assign centre_s = (samp_cnt_r == CTR_C);

  // Two-flop synchroniser on the asynchronous serial line.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_in;
      rx_d2 <= rx_d1;
    end
  end

  // FSM state register.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:   if (!rx_d2) state_s = START; else state_s = IDLE;
      START:  if (mid_s) state_s = rx_d2 ? IDLE : DATA; else state_s = START;
      DATA: begin
        if (centre_s && bit_cnt_r == LAST_C) state_s = (PARITY_EN != 0) ? PARITY : STOP;
        else state_s = DATA;
      end
      PARITY: if (centre_s) state_s = STOP; else state_s = PARITY;
      // A low stop bit parks in BREAK so a held-low line yields one word only.
      STOP:   if (centre_s) state_s = rx_d2 ? IDLE : BREAK; else state_s = STOP;
      BREAK:  if (rx_d2) state_s = IDLE; else state_s = BREAK;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: push the completed word at the stop-bit centre.
  always_comb begin
    push_s = 1'b0;
    if (state_r == STOP && centre_s) push_s = 1'b1;
    else                             push_s = 1'b0;
    push_word_s = {~rx_d2, perr_r, shift_r};
  end

  // Sample/bit counters, LSB-first shifter and parity check.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      samp_cnt_r <= {SW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      shift_r    <= {WIDTH{1'b0}};
      perr_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          samp_cnt_r <= rx_d2 ? {SW{1'b0}} : SW'(1);
          bit_cnt_r  <= {BW{1'b0}};
        end
        START: begin
          if (mid_s) begin
            samp_cnt_r <= {SW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            perr_r     <= 1'b0;
          end else begin
            samp_cnt_r <= samp_cnt_r + SW'(1);
          end
        end
        DATA, PARITY, STOP: begin
          samp_cnt_r <= centre_s ? {SW{1'b0}} : samp_cnt_r + SW'(1);
          if (centre_s && state_r == DATA) begin
            shift_r   <= WIDTH'({rx_d2, shift_r} >> 1);
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
          if (centre_s && state_r == PARITY) begin
            perr_r <= calc_parity(MAX_WIDTH'(shift_r), ODD_C) ^ rx_d2;
          end
        end
        default: samp_cnt_r <= {SW{1'b0}};
      endcase
    end
  end

  // A push against a full buffer with no simultaneous pop is dropped.
  assign drop_s = push_s && (fifo_count_s == CW'(FIFO_DEPTH)) && !(uld_rx_data && !rx_empty);

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n)         overrun_r <= 1'b0;
    else if (drop_s)      overrun_r <= 1'b1;
    else if (clr_overrun) overrun_r <= 1'b0;
    else                  overrun_r <= overrun_r;
  end

  uart_rx_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rxclk),
    .reset_n (reset_n),
    .wr_en   (push_s),
    .wr_data (push_word_s),
    .rd_en   (uld_rx_data),
    .rd_data (head_s),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (fifo_count_s)
  );

  assign rx_data = head_s[WIDTH-1:0];
  assign rx_perr = head_s[WIDTH];
  assign rx_ferr = head_s[WIDTH+1];
  assign overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized checks of uart_rx_param against a queue-based reference model.
module tb_uart_rx_param;

  localparam int OS = 16;
  localparam int W  = 18;
  localparam int L1 = 2 + OS / 2 + OS * (W + 1);

  logic rxclk = 1'b0;
  logic reset_n, rx_a, uld_a, clr_a, rx_b, uld_b, clr_b;
  logic [W-1:0] data_a;
  logic perr_a, ferr_a, empty_a, full_a, ovr_a;
  logic [7:0] data_b;
  logic perr_b, ferr_b, empty_b, full_b, ovr_b;

  int checks = 0;
  int errors = 0;
  logic [19:0] q_m[$];
  logic ovr_m;
  logic [17:0] rd;
  logic [7:0]  rb;
  logic        rbad, rpb, exp_perr;
  int          lo;
  logic [19:0] dropped;

  always #5 rxclk = ~rxclk;

  uart_rx_param dut (
    .rxclk(rxclk), .reset_n(reset_n), .rx_in(rx_a), .uld_rx_data(uld_a), .clr_overrun(clr_a),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_empty(empty_a),
    .rx_full(full_a), .overrun(ovr_a)
  );

  uart_rx_param #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .rxclk(rxclk), .reset_n(reset_n), .rx_in(rx_b), .uld_rx_data(uld_b), .clr_overrun(clr_b),
    .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b), .rx_empty(empty_b),
    .rx_full(full_b), .overrun(ovr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial frame, LSB first: start bit, data, optional parity, stop, then idle-high.
  function automatic logic [127:0] frame(input logic [63:0] d, input int w, input int pen,
                                         input logic pbit, input logic stop);
    logic [127:0] f;
    int idx;
    f = {128{1'b1}};
    f[0] = 1'b0;
    for (int i = 0; i < w; i++) f[1+i] = d[i];
    idx = 1 + w;
    if (pen != 0) begin
      f[idx] = pbit;
      idx++;
    end
    f[idx] = stop;
    return f;
  endfunction

  task automatic send(input int sel, input logic [127:0] f, input int n, input int pop_at,
                      output int low_at);
    low_at = -1;
    for (int k = 0; k < n * OS; k++) begin
      @(negedge rxclk);
      if (low_at < 0 && ((sel == 0) ? !empty_a : !empty_b)) low_at = k;
      if (sel == 0) begin
        rx_a  = f[k / OS];
        uld_a = (k == pop_at);
      end else begin
        rx_b  = f[k / OS];
        uld_b = (k == pop_at);
      end
    end
    @(negedge rxclk);
    rx_a = 1'b1; rx_b = 1'b1; uld_a = 1'b0; uld_b = 1'b0;
  endtask

  task automatic idle(input int c);
    rx_a = 1'b1; rx_b = 1'b1;
    repeat (c) @(negedge rxclk);
  endtask

  function automatic void model_push(input logic [19:0] w);
    if (q_m.size() == 4) ovr_m = 1'b1;
    else q_m.push_back(w);
  endfunction

  task automatic chk_flags(input string tag);
    chk({tag, "_empty"},   64'(empty_a), 64'(q_m.size() == 0));
    chk({tag, "_full"},    64'(full_a),  64'(q_m.size() == 4));
    chk({tag, "_overrun"}, 64'(ovr_a),   64'(ovr_m));
  endtask

  task automatic pop_a(input string tag);
    logic [19:0] e;
    e = q_m.pop_front();
    chk({tag, "_nempty"}, 64'(empty_a), 64'd0);
    chk({tag, "_word"}, 64'({ferr_a, perr_a, data_a}), 64'(e));
    uld_a = 1'b1;
    @(negedge rxclk);
    uld_a = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [9:0] e);
    chk({tag, "_nempty"}, 64'(empty_b), 64'd0);
    chk({tag, "_word"}, 64'({ferr_b, perr_b, data_b}), 64'(e));
    uld_b = 1'b1;
    @(negedge rxclk);
    uld_b = 1'b0;
    chk({tag, "_empty"}, 64'(empty_b), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  64'(data_a),  64'd0);
    chk({tag, "_perr"},  64'(perr_a),  64'd0);
    chk({tag, "_ferr"},  64'(ferr_a),  64'd0);
    chk({tag, "_empty"}, 64'(empty_a), 64'd1);
    chk({tag, "_full"},  64'(full_a),  64'd0);
    chk({tag, "_ovr"},   64'(ovr_a),   64'd0);
  endtask

  initial begin
    reset_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    uld_a = 1'b0; uld_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    ovr_m = 1'b0;
    repeat (3) @(negedge rxclk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    idle(4);

    // Good frame with exact empty-flag latency.
    send(0, frame(64'h2A5C3, W, 0, 1'b0, 1'b1), W + 2, -1, lo);
    chk("t1_latency", 64'(lo), 64'(L1));
    model_push({2'b00, 18'h2A5C3});
    idle(8);
    chk_flags("t1");
    pop_a("t1_pop");
    chk_flags("t1_after");

    // Runt start pulse, then a real frame.
    rx_a = 1'b0;
    repeat (4) @(negedge rxclk);
    idle(3 * OS);
    chk_flags("t2_runt");
    send(0, frame(64'h00001, W, 0, 1'b0, 1'b1), W + 2, -1, lo);
    model_push({2'b00, 18'h00001});
    idle(8);
    pop_a("t2_pop");

    // Even parity on the 8-bit instance.
    send(1, frame(64'hA5, 8, 1, 1'b0, 1'b1), 11, -1, lo);
    idle(8);
    pop_b("t3_good", {2'b00, 8'hA5});
    send(1, frame(64'hA5, 8, 1, 1'b1, 1'b1), 11, -1, lo);
    idle(8);
    pop_b("t3_bad", {2'b01, 8'hA5});
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      rpb = 1'($urandom_range(0, 1));
      exp_perr = ((($countones(rb) + int'(rpb)) % 2) != 0);
      send(1, frame(64'(rb), 8, 1, rpb, 1'b1), 11, -1, lo);
      idle(8);
      pop_b("t3_rnd", {1'b0, exp_perr, rb});
    end

    // Stop bit low and line held low for five more bit periods.
    send(0, {128{1'b0}}, W + 2 + 5, -1, lo);
    idle(4 * OS);
    model_push({2'b10, 18'h00000});
    chk_flags("t4_break");
    pop_a("t4_pop");
    chk_flags("t4_one_word");
    send(0, frame(64'h3FFFF, W, 0, 1'b0, 1'b1), W + 2, -1, lo);
    model_push({2'b00, 18'h3FFFF});
    idle(8);
    pop_a("t4_next");

    // Randomized frames with random framing errors and unloads.
    for (int i = 0; i < 10; i++) begin
      rd = 18'($urandom);
      rbad = ($urandom_range(0, 3) == 0);
      send(0, frame(64'(rd), W, 0, 1'b0, !rbad), W + 2, -1, lo);
      model_push({rbad, 1'b0, rd});
      idle(2 * OS);
      chk_flags("rnd");
      if ($urandom_range(0, 1) == 1 && q_m.size() > 0) pop_a("rnd_pop");
    end
    while (q_m.size() > 0) pop_a("drain");
    clr_a = 1'b1;
    @(negedge rxclk);
    clr_a = 1'b0;
    ovr_m = 1'b0;
    chk_flags("drain");

    // Fill to full, overflow, drain, clear.
    for (int i = 1; i <= 5; i++) begin
      send(0, frame(64'(i), W, 0, 1'b0, 1'b1), W + 2, -1, lo);
      model_push({2'b00, 18'(i)});
      idle(2 * OS);
      chk_flags("t5_fill");
    end
    for (int i = 0; i < 4; i++) pop_a("t5_pop");
    clr_a = 1'b1;
    @(negedge rxclk);
    clr_a = 1'b0;
    ovr_m = 1'b0;
    chk_flags("t5_clr");

    // Pop coinciding with the push into a full buffer.
    for (int i = 6; i <= 9; i++) begin
      send(0, frame(64'(i), W, 0, 1'b0, 1'b1), W + 2, -1, lo);
      model_push({2'b00, 18'(i)});
      idle(2 * OS);
    end
    chk_flags("t5_full2");
    send(0, frame(64'd10, W, 0, 1'b0, 1'b1), W + 2, L1 - 1, lo);
    dropped = q_m.pop_front();
    q_m.push_back({2'b00, 18'd10});
    idle(2 * OS);
    chk_flags("t5_pushpop");
    for (int i = 0; i < 4; i++) pop_a("t5_pop2");

    // Reset in the middle of data bit 9 with a word already buffered.
    send(0, frame(64'h12345, W, 0, 1'b0, 1'b1), W + 2, -1, lo);
    model_push({2'b00, 18'h12345});
    idle(2 * OS);
    chk_flags("t6_pre");
    send(0, frame(64'h2AAAA, W, 0, 1'b0, 1'b1), 10, -1, lo);
    repeat (5) @(negedge rxclk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("t6_rst");
    q_m.delete();
    ovr_m = 1'b0;
    repeat (3) @(negedge rxclk);
    reset_n = 1'b1;
    idle(2 * OS);
    chk_flags("t6_post");
    send(0, frame(64'h15555, W, 0, 1'b0, 1'b1), W + 2, -1, lo);
    model_push({2'b00, 18'h15555});
    idle(8);
    pop_a("t6_pop");
    chk_flags("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
